// File: rtl/bus_resp.sv
// Master-side response collector: latches the one-hot slave select, waits for that slave's ack,
// returns its read data with a one-cycle M_ack. Optional timeout via BUS_RESP_TIMEOUT_EN.
module bus_resp #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              M_req,
    input  logic              M_wr,
    input  logic              S0_sel,
    input  logic              S1_sel,
    input  logic              S2_sel,
    input  logic              S3_sel,
    input  logic              S0_ack,
    input  logic              S1_ack,
    input  logic              S2_ack,
    input  logic              S3_ack,
    input  logic [DATA_W-1:0] S0_dout,
    input  logic [DATA_W-1:0] S1_dout,
    input  logic [DATA_W-1:0] S2_dout,
    input  logic [DATA_W-1:0] S3_dout,
    output logic [DATA_W-1:0] M_din,
    output logic              M_ack,
    output logic              M_err,
    output logic              M_busy
);

    // Handshake: M_req is sampled only in IDLE; M_ack is a single-cycle pulse that
    // carries M_err and M_din, and the master may not issue a new request before it.

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    state_t      state;
    logic [3:0]  sel_q;
    logic        wr_q;
    logic [3:0]  req_sel;
    logic [3:0]  ack_vec;
    logic        req_one_hot;
    logic        sel_ack;
    logic [DATA_W-1:0] sel_dout;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("bus_resp: TIMEOUT must be within 1..255");
    end

    assign req_sel     = {S3_sel, S2_sel, S1_sel, S0_sel};
    assign ack_vec     = {S3_ack, S2_ack, S1_ack, S0_ack};
    assign req_one_hot = (req_sel != 4'd0) && ((req_sel & (req_sel - 4'd1)) == 4'd0);
    // Only the latched slave's ack can complete the access.
    assign sel_ack     = |(sel_q & ack_vec);

    always_comb begin
        sel_dout = '0;
        case (sel_q)
            4'b0001: sel_dout = S0_dout;
            4'b0010: sel_dout = S1_dout;
            4'b0100: sel_dout = S2_dout;
            4'b1000: sel_dout = S3_dout;
            default: sel_dout = '0;
        endcase
    end

`ifdef BUS_RESP_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sel_q  <= 4'd0;
            wr_q   <= 1'b0;
            M_din  <= '0;
            M_ack  <= 1'b0;
            M_err  <= 1'b0;
            M_busy <= 1'b0;
`ifdef BUS_RESP_TIMEOUT_EN
            cnt    <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    M_ack <= 1'b0;
                    M_err <= 1'b0;
                    M_din <= '0;
                    if (M_req) begin
                        M_busy <= 1'b1;
                        if (req_one_hot) begin
                            sel_q <= req_sel;
                            wr_q  <= M_wr;
`ifdef BUS_RESP_TIMEOUT_EN
                            cnt   <= 8'd0;
`endif
                            state <= WAIT;
                        end else begin
                            // Decode error answers immediately from the ERR state.
                            M_ack <= 1'b1;
                            M_err <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                WAIT: begin
                    if (sel_ack) begin
                        M_din <= wr_q ? '0 : sel_dout;
                        M_ack <= 1'b1;
                        M_err <= 1'b0;
                        state <= RESP;
`ifdef BUS_RESP_TIMEOUT_EN
                    end else if (cnt == CNT_LAST) begin
                        M_din <= '0;
                        M_ack <= 1'b1;
                        M_err <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
`endif
                    end
                end
                RESP, ERR: begin
                    M_din  <= '0;
                    M_ack  <= 1'b0;
                    M_err  <= 1'b0;
                    M_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
